// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cfg_sequencer
//  Description : Table-driven register-init sequencer. After a start pulse it
//                walks an external ROM of {reg, data} entries and issues one
//                single-byte write per entry to the I2C/SCCB request manager.
//                It honours delay (reg 8'hFE) and end (16'hFFFF) markers,
//                retries NACKed transactions and reports busy/done/error.
//  Optional    : `define I2C_CFG_READBACK_EN adds a verify read after every
//                successful write; a mismatching read-back flags an error.
//  Ports       : i_clk/i_rst_n      clock, asynchronous active-low reset
//                i_start            start pulse (ignored while busy)
//                o_rom_addr/i_rom_data  table ROM (1-cycle read latency)
//                o_valid/i_ready    request handshake to the manager
//                o_we, o_sccb_mode, o_addr_slave, o_addr_reg, o_burst_num
//                                   request descriptor
//                o_valid_wr_byte/o_wr_byte/i_ready_wr_byte  write byte stream
//                i_nack, i_rd_valid, i_rd_byte, i_txn_done  manager status
//                o_busy, o_done, o_error   sequence status (done/error sticky)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_cfg_sequencer #(
   parameter int         ROM_AW     = 8,
   parameter logic [6:0] SLAVE_ADDR = 7'h21,
   parameter int         SCCB_MODE  = 1,
   parameter int         DELAY_UNIT = 25000,
   parameter int         MAX_RETRY  = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [15:0]       i_rom_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_we,
   output logic              o_sccb_mode,
   output logic [6:0]        o_addr_slave,
   output logic [7:0]        o_addr_reg,
   output logic [3:0]        o_burst_num,
   output logic              o_valid_wr_byte,
   output logic [7:0]        o_wr_byte,
   input  logic              i_ready_wr_byte,
   input  logic              i_nack,
   input  logic              i_rd_valid,
   input  logic [7:0]        i_rd_byte,
   input  logic              i_txn_done,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   localparam logic [31:0] DELAY_UNIT_C = 32'(DELAY_UNIT);
   localparam logic [7:0]  MAX_RETRY_C  = 8'(MAX_RETRY);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_REQ     = 4'd3,
      ST_WAIT    = 4'd4,
      ST_DELAY   = 4'd5,
`ifdef I2C_CFG_READBACK_EN
      ST_RB_REQ  = 4'd6,
      ST_RB_WAIT = 4'd7,
`endif
      ST_DONE    = 4'd8,
      ST_ERROR   = 4'd9
   } state_t;

   state_t            state_q;
   logic [ROM_AW-1:0] rom_addr_q;
   logic              valid_q;
   logic              we_q;
   logic [7:0]        addr_reg_q;
   logic              valid_wr_byte_q;
   logic [7:0]        wr_byte_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic [7:0]        retry_q;
   logic              nack_seen_q;
   logic [31:0]       delay_q;

   logic [ROM_AW-1:0] rom_addr_d;
   logic              addr_last;
   logic [31:0]       delay_total;
   logic              txn_failed;
   logic              retry_ok;

   assign rom_addr_d  = rom_addr_q + ROM_AW'(1);
   // Incrementing past the last entry would wrap to 0: treat it as end of table.
   assign addr_last   = &rom_addr_q;
   assign delay_total = {24'd0, i_rom_data[7:0]} * DELAY_UNIT_C;
   // A NACK in the same cycle as txn_done still fails the transaction.
   assign txn_failed  = nack_seen_q | i_nack;
   assign retry_ok    = retry_q < MAX_RETRY_C;

`ifdef I2C_CFG_READBACK_EN
   logic [7:0] rd_byte_q;
   logic       rd_seen_q;
   logic [7:0] rd_cmp;
   logic       rd_have;
   // The read byte may arrive in the same cycle as txn_done.
   assign rd_cmp  = i_rd_valid ? i_rd_byte : rd_byte_q;
   assign rd_have = i_rd_valid | rd_seen_q;
`else
   logic unused_rd;
   assign unused_rd = ^{i_rd_valid, i_rd_byte};
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q         <= ST_IDLE;
         rom_addr_q      <= '0;
         valid_q         <= 1'b0;
         we_q            <= 1'b0;
         addr_reg_q      <= 8'd0;
         valid_wr_byte_q <= 1'b0;
         wr_byte_q       <= 8'd0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         retry_q         <= 8'd0;
         nack_seen_q     <= 1'b0;
         delay_q         <= 32'd0;
`ifdef I2C_CFG_READBACK_EN
         rd_byte_q       <= 8'd0;
         rd_seen_q       <= 1'b0;
`endif
      end else begin
         // The write-byte stream handshakes independently of the request.
         if (valid_wr_byte_q && i_ready_wr_byte) valid_wr_byte_q <= 1'b0;
         // Sticky until the next attempt is issued (cleared below).
         if (i_nack) nack_seen_q <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
         if (i_rd_valid) begin
            rd_byte_q <= i_rd_byte;
            rd_seen_q <= 1'b1;
         end
`endif
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  rom_addr_q <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  retry_q    <= 8'd0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_FETCH;
               end
            end

            ST_FETCH: state_q <= ST_DECODE;

            ST_DECODE: begin
               if (i_rom_data == 16'hFFFF) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else if (i_rom_data[15:8] == 8'hFE) begin
                  if (addr_last) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     // The next entry is prefetched during the delay, so the
                     // following DECODE lands delay_total cycles after this one
                     // (never sooner than the 2-cycle FETCH path allows).
                     rom_addr_q <= rom_addr_d;
                     if (delay_total <= 32'd2) begin
                        state_q <= ST_FETCH;
                     end else begin
                        delay_q <= delay_total - 32'd2;
                        state_q <= ST_DELAY;
                     end
                  end
               end else begin
                  addr_reg_q      <= i_rom_data[15:8];
                  wr_byte_q       <= i_rom_data[7:0];
                  valid_q         <= 1'b1;
                  we_q            <= 1'b1;
                  valid_wr_byte_q <= 1'b1;
                  nack_seen_q     <= 1'b0;
                  state_q         <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (i_txn_done) begin
                  if (txn_failed) begin
                     if (retry_ok) begin
                        retry_q         <= retry_q + 8'd1;
                        valid_q         <= 1'b1;
                        we_q            <= 1'b1;
                        valid_wr_byte_q <= 1'b1;
                        nack_seen_q     <= 1'b0;
                        state_q         <= ST_REQ;
                     end else begin
                        error_q         <= 1'b1;
                        busy_q          <= 1'b0;
                        valid_wr_byte_q <= 1'b0;
                        state_q         <= ST_ERROR;
                     end
                  end else begin
`ifdef I2C_CFG_READBACK_EN
                     valid_q     <= 1'b1;
                     we_q        <= 1'b0;
                     nack_seen_q <= 1'b0;
                     rd_seen_q   <= 1'b0;
                     state_q     <= ST_RB_REQ;
`else
                     retry_q <= 8'd0;
                     if (addr_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                     end else begin
                        rom_addr_q <= rom_addr_d;
                        state_q    <= ST_FETCH;
                     end
`endif
                  end
               end
            end

`ifdef I2C_CFG_READBACK_EN
            ST_RB_REQ: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_RB_WAIT;
               end
            end

            ST_RB_WAIT: begin
               if (i_txn_done) begin
                  if (txn_failed) begin
                     // Retry counter is shared with the preceding write.
                     if (retry_ok) begin
                        retry_q     <= retry_q + 8'd1;
                        valid_q     <= 1'b1;
                        nack_seen_q <= 1'b0;
                        rd_seen_q   <= 1'b0;
                        state_q     <= ST_RB_REQ;
                     end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_ERROR;
                     end
                  end else if (!rd_have || (rd_cmp != wr_byte_q)) begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_ERROR;
                  end else begin
                     retry_q <= 8'd0;
                     if (addr_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                     end else begin
                        rom_addr_q <= rom_addr_d;
                        state_q    <= ST_FETCH;
                     end
                  end
               end
            end
`endif

            ST_DELAY: begin
               if (delay_q == 32'd0) state_q <= ST_DECODE;
               else                  delay_q <= delay_q - 32'd1;
            end

            ST_DONE:  state_q <= ST_IDLE;
            ST_ERROR: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_rom_addr      = rom_addr_q;
   assign o_valid         = valid_q;
   assign o_we            = we_q;
   assign o_sccb_mode     = (SCCB_MODE != 0);
   assign o_addr_slave    = SLAVE_ADDR;
   assign o_addr_reg      = addr_reg_q;
   assign o_burst_num     = 4'd0;
   assign o_valid_wr_byte = valid_wr_byte_q;
   assign o_wr_byte       = wr_byte_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cfg_sequencer
//  Description : Self-checking bench for i2c_cfg_sequencer. A ROM model and a
//                request-manager responder drive the DUT; a table-walking
//                reference model predicts the request list and final flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_cfg_sequencer;

   localparam int MAX_RETRY = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start = 1'b0;
   logic [7:0]  o_rom_addr;
   logic [15:0] rom_q;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic        o_we;
   logic        o_sccb_mode;
   logic [6:0]  o_addr_slave;
   logic [7:0]  o_addr_reg;
   logic [3:0]  o_burst_num;
   logic        o_valid_wr_byte;
   logic [7:0]  o_wr_byte;
   logic        i_ready_wr_byte = 1'b0;
   logic        i_nack = 1'b0;
   logic        i_rd_valid = 1'b0;
   logic [7:0]  i_rd_byte = 8'd0;
   logic        i_txn_done = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   always #5 clk = ~clk;

   i2c_cfg_sequencer #(
      .ROM_AW     (8),
      .SLAVE_ADDR (7'h21),
      .SCCB_MODE  (1),
      .DELAY_UNIT (4),
      .MAX_RETRY  (MAX_RETRY)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (i_start),
      .o_rom_addr      (o_rom_addr),
      .i_rom_data      (rom_q),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_we            (o_we),
      .o_sccb_mode     (o_sccb_mode),
      .o_addr_slave    (o_addr_slave),
      .o_addr_reg      (o_addr_reg),
      .o_burst_num     (o_burst_num),
      .o_valid_wr_byte (o_valid_wr_byte),
      .o_wr_byte       (o_wr_byte),
      .i_ready_wr_byte (i_ready_wr_byte),
      .i_nack          (i_nack),
      .i_rd_valid      (i_rd_valid),
      .i_rd_byte       (i_rd_byte),
      .i_txn_done      (i_txn_done),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_error         (o_error)
   );

   // Synchronous ROM: data valid one cycle after the address changes.
   logic [15:0] rom [256];
   always @(posedge clk) rom_q <= rom[o_rom_addr];

   int          n_vec = 0;
   int          n_err = 0;
   int          nack_plan[$];
   logic [7:0]  rd_xor = 8'd0;
   logic [31:0] got[$];
   logic [31:0] exp_q[$];
   int          req_cyc[$];
   int          done_cyc[$];
   logic        exp_done, exp_err;
   int          stab_bad, slave_bad;
   logic        timed_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] pack_req(input logic [7:0] r, input logic [7:0] d, input logic we);
      return {15'd0, r, d, we};
   endfunction

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
   endtask

   // Reference model: walk the table, one request per attempt, consuming the
   // NACK plan in order; retries are per entry, error once they run out.
   task automatic build_expect();
      int k, r, nk;
      logic [15:0] e;
      exp_q.delete();
      exp_err = 1'b0;
      k = 0;
      for (int i = 0; i < 256 && !exp_err; i++) begin
         e = rom[i];
         if (e == 16'hFFFF) break;
         if (e[15:8] == 8'hFE) continue;
         r = 0;
         for (int a = 0; a < 64; a++) begin
            exp_q.push_back(pack_req(e[15:8], e[7:0], 1'b1));
            nk = (k < nack_plan.size()) ? nack_plan[k] : 0;
            k++;
            if (nk == 0) break;
            if (r < MAX_RETRY) r++;
            else begin exp_err = 1'b1; break; end
         end
`ifdef I2C_CFG_READBACK_EN
         if (!exp_err) begin
            for (int a = 0; a < 64; a++) begin
               exp_q.push_back(pack_req(e[15:8], e[7:0], 1'b0));
               nk = (k < nack_plan.size()) ? nack_plan[k] : 0;
               k++;
               if (nk == 0) begin
                  if (rd_xor != 8'd0) exp_err = 1'b1;
                  break;
               end
               if (r < MAX_RETRY) r++;
               else begin exp_err = 1'b1; break; end
            end
         end
`endif
      end
      exp_done = !exp_err;
   endtask

   // Start a sequence and act as the request manager until it finishes.
   // force_hold >= 0 fixes the cycles i_ready is withheld per request.
   task automatic run_seq(input int budget, input int force_hold, input bit start_on_done);
      int cyc, phase, hold, cnt, nack_at, nk, pidx;
      logic [7:0] rec_reg, rec_byte;
      logic       rec_we;
      got.delete(); req_cyc.delete(); done_cyc.delete();
      stab_bad = 0; slave_bad = 0; timed_out = 1'b0;
      phase = 0; pidx = 0; hold = 0; cnt = 0; nack_at = 0; nk = 0;
      rec_reg = 8'd0; rec_byte = 8'd0; rec_we = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 1;
      while (1) begin
         i_ready = 1'b0; i_ready_wr_byte = 1'b0; i_nack = 1'b0;
         i_txn_done = 1'b0; i_rd_valid = 1'b0;
         if (!o_busy && (o_done || o_error)) begin
            if (start_on_done) i_start = 1'b1;
            break;
         end
         if (cyc >= budget) begin timed_out = 1'b1; break; end
         if (phase == 0 && o_valid) begin
            rec_reg = o_addr_reg; rec_byte = o_wr_byte; rec_we = o_we;
            got.push_back(pack_req(rec_reg, rec_byte, rec_we));
            req_cyc.push_back(cyc);
            if (o_addr_slave !== 7'h21 || o_sccb_mode !== 1'b1 || o_burst_num !== 4'd0)
               slave_bad++;
            hold  = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
            phase = 1;
         end
         if (phase == 1) begin
            if (o_valid !== 1'b1 || o_addr_reg !== rec_reg || o_wr_byte !== rec_byte || o_we !== rec_we)
               stab_bad++;
            if (hold == 0) begin
               i_ready = 1'b1;
               phase   = 2;
               cnt     = $urandom_range(2, 6);
               nk      = (pidx < nack_plan.size()) ? nack_plan[pidx] : 0;
               pidx++;
               nack_at = $urandom_range(0, cnt - 1);
            end else begin
               hold--;
            end
         end else if (phase == 2) begin
            cnt--;
            if (o_valid_wr_byte) i_ready_wr_byte = 1'($urandom_range(0, 1));
            if (nk != 0 && cnt == nack_at) i_nack = 1'b1;
            if (!rec_we && cnt == 1) begin
               i_rd_valid = 1'b1;
               i_rd_byte  = rec_byte ^ rd_xor;
            end
            if (cnt == 0) begin
               i_txn_done = 1'b1;
               done_cyc.push_back(cyc);
               phase = 0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic compare_run(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check({tag, "_req"}, got[i], exp_q[i]);
      check({tag, "_done"},    {31'd0, o_done},  {31'd0, exp_done});
      check({tag, "_error"},   {31'd0, o_error}, {31'd0, exp_err});
      check({tag, "_busy"},    {31'd0, o_busy},  32'd0);
      check({tag, "_stable"},  stab_bad,  32'd0);
      check({tag, "_slave"},   slave_bad, 32'd0);
      check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
   endtask

   function automatic logic [31:0] out_vec();
      return {2'd0, o_rom_addr, o_valid, o_valid_wr_byte, o_we, o_addr_reg, o_wr_byte,
              o_busy, o_done, o_error};
   endfunction

   initial begin
      int vcount;
      rom_clear();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      // Reset state
      check("reset_outputs", out_vec(), 32'd0);
      check("reset_static", {20'd0, o_sccb_mode, o_addr_slave, o_burst_num}, {20'd0, 1'b1, 7'h21, 4'd0});
      rst_n = 1'b1;
      @(negedge clk);

      // Single write; start during the DONE cycle must be ignored
      rom_clear(); rom[0] = 16'h1280;
      nack_plan.delete();
      build_expect();
      run_seq(200, 0, 1'b1);
      compare_run("single");
      check("single_latency", req_cyc.size() > 0 ? req_cyc[0] : -1, 32'd3);
      check("single_exp_req", exp_q.size() > 0 ? exp_q[0] : 0, pack_req(8'h12, 8'h80, 1'b1));

      // Delay marker: 2 x 4 cycles, request at cycle 11
      rom_clear(); rom[0] = 16'hFE02; rom[1] = 16'h1101;
      build_expect();
      run_seq(200, 0, 1'b0);
      compare_run("delay");
      check("delay_latency", req_cyc.size() > 0 ? req_cyc[0] : -1, 32'd11);

      // txn_done to next request gap
      rom_clear(); rom[0] = 16'h1280; rom[1] = 16'h3456;
      build_expect();
      run_seq(200, 1, 1'b0);
      compare_run("gap");
      check("gap_cycles", (req_cyc.size() > 1 && done_cyc.size() > 0) ? req_cyc[1] - done_cyc[0] : -1, 32'd3);

      // Two NACKs then clean
      rom_clear(); rom[0] = 16'h2233;
      nack_plan = '{1, 1, 0};
      build_expect();
      run_seq(300, -1, 1'b0);
      compare_run("nack_retry");

      // Retries exhausted: no further requests afterwards
      nack_plan = '{1, 1, 1, 1, 1, 1};
      build_expect();
      run_seq(300, -1, 1'b0);
      compare_run("exhaust");
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_valid) vcount++;
         @(negedge clk);
      end
      check("exhaust_quiet", vcount, 32'd0);
      nack_plan.delete();

      // Backpressure: ready withheld 10 cycles
      rom_clear(); rom[0] = 16'h5A5A; rom[1] = 16'h0102;
      build_expect();
      run_seq(400, 10, 1'b0);
      compare_run("backpressure");

      // Randomised tables and NACK patterns
      for (int it = 0; it < 20; it++) begin
         int n, pct;
         rom_clear();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
            else                           rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
         end
         pct = (it % 4 == 3) ? 80 : 20;
         nack_plan.delete();
         for (int i = 0; i < 64; i++) nack_plan.push_back(($urandom_range(0, 99) < pct) ? 1 : 0);
         build_expect();
         run_seq(3000, -1, 1'b0);
         compare_run("random");
      end
      nack_plan.delete();

`ifdef I2C_CFG_READBACK_EN
      // Readback mismatch then match
      rom_clear(); rom[0] = 16'h123A;
      rd_xor = 8'h01;
      build_expect();
      run_seq(300, 0, 1'b0);
      compare_run("rb_mismatch");
      rd_xor = 8'h00;
      build_expect();
      run_seq(300, 0, 1'b0);
      compare_run("rb_match");
`endif

      // Reset while waiting for txn_done
      rom_clear(); rom[0] = 16'h1280;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      for (int i = 0; i < 10 && !o_valid; i++) @(negedge clk);
      check("rst_req_seen", {31'd0, o_valid}, 32'd1);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check("rst_in_wait", {30'd0, o_busy, o_valid}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", out_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
